// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory, decode and redirect signals of the fetch stage
interface instruction_fetch_if;
  logic [7:0] instruction_address;
  logic [7:0] instruction_data;
  logic       decode_ready;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] instr_reg;
  logic [7:0] instr_pc;
  logic       instr_valid;

  modport master (
    output instruction_address, instr_reg, instr_pc, instr_valid,
    input  instruction_data, decode_ready, branch_taken, branch_target
  );

  modport slave (
    input  instruction_address, instr_reg, instr_pc, instr_valid,
    output instruction_data, decode_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-stage instruction fetch with stall, halt, branch redirect and fault
module instruction_fetch #(
  parameter int         MEM_DEPTH   = 64,
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus,
  output logic [1:0]          fetch_state,
  output logic                fetch_fault,
  output logic [15:0]         fetch_count
);
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HALTED = 2'b01,
    FAULT  = 2'b10
  } state_t;

  localparam logic [7:0] LAST_PC = 8'(MEM_DEPTH - 1);
  localparam logic [8:0] DEPTH   = 9'(MEM_DEPTH);

  state_t      state, state_next;
  logic [7:0]  pc, pc_next;
  logic [7:0]  ir, ir_next;
  logic [7:0]  ipc, ipc_next;
  logic        valid, valid_next;
  logic [15:0] count, count_next;
  logic        accept;
  logic        target_ok;

  assign accept    = valid & bus.decode_ready;
  assign target_ok = {1'b0, bus.branch_target} < DEPTH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      ir    <= 8'h00;
      ipc   <= 8'h00;
      valid <= 1'b0;
      count <= 16'h0000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      ipc   <= ipc_next;
      valid <= valid_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    ipc_next   = ipc;
    valid_next = valid;
    count_next = count;
    // A redirect flushes whatever is presented, so it is never counted as accepted.
    if (state != FAULT && bus.branch_taken) begin
      valid_next = 1'b0;
      if (target_ok) begin
        pc_next    = bus.branch_target;
        state_next = RUN;
      end else begin
        state_next = FAULT;
      end
    end else begin
      if (accept && count != 16'hFFFF)
        count_next = count + 16'd1;
      case (state)
        RUN: begin
          if (!valid || accept) begin
            ir_next    = bus.instruction_data;
            ipc_next   = pc;
            valid_next = 1'b1;
            if (bus.instruction_data == HALT_OPCODE)
              state_next = HALTED;
            else
              pc_next = (pc == LAST_PC) ? 8'h00 : pc + 8'd1;
          end
        end
        HALTED: begin
          if (accept)
            valid_next = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.instruction_address = pc;
  assign bus.instr_reg           = ir;
  assign bus.instr_pc            = ipc;
  assign bus.instr_valid         = valid;
  assign fetch_state             = state;
  assign fetch_fault             = (state == FAULT);
  assign fetch_count             = count;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  fetch_state;
  logic        fetch_fault;
  logic [15:0] fetch_count;
  logic [7:0]  mem [0:255];
  int          passed = 0;
  int          total = 0;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] word;
  } exp_t;
  exp_t sb[$];
  exp_t exp_item;

  instruction_fetch_if bus();

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .fetch_state (fetch_state),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  assign bus.instruction_data = mem[bus.instruction_address];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = 8'h00;
    bus.decode_ready = 1'b0;
    sb.delete();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = 8'h00;
    bus.decode_ready = 1'b0;
    #3;
    total++; if (bus.instruction_address !== 8'h00) $display("FAIL reset_pc got %h exp 00", bus.instruction_address); else passed++;
    total++; if (bus.instr_reg !== 8'h00) $display("FAIL reset_instr got %h exp 00", bus.instr_reg); else passed++;
    total++; if (bus.instr_pc !== 8'h00) $display("FAIL reset_instr_pc got %h exp 00", bus.instr_pc); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.instr_valid); else passed++;
    total++; if (fetch_state !== 2'b00) $display("FAIL reset_state got %b exp 00", fetch_state); else passed++;
    total++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault got %b exp 0", fetch_fault); else passed++;
    total++; if (fetch_count !== 16'h0000) $display("FAIL reset_count got %h exp 0000", fetch_count); else passed++;
  endtask

  task automatic test_straight_line();
    apply_reset();
    sb.push_back({8'd0, 8'h11});
    sb.push_back({8'd1, 8'h22});
    sb.push_back({8'd2, 8'h33});
    sb.push_back({8'd3, 8'h44});
    bus.decode_ready = 1'b1;
    step();
    for (int c = 1; c <= 20 && sb.size() > 0; c++) begin
      if (bus.instr_valid && bus.decode_ready) begin
        exp_item = sb.pop_front();
        total++; if (bus.instr_reg !== exp_item.word) $display("FAIL straight_instr got %h exp %h", bus.instr_reg, exp_item.word); else passed++;
        total++; if (bus.instr_pc !== exp_item.pc) $display("FAIL straight_pc got %h exp %h", bus.instr_pc, exp_item.pc); else passed++;
      end
      step();
    end
    bus.decode_ready = 1'b0;
    total++; if (sb.size() != 0) $display("FAIL straight_timeout left %0d exp 0", sb.size()); else passed++;
    total++; if (fetch_count !== 16'd4) $display("FAIL straight_count got %0d exp 4", fetch_count); else passed++;
  endtask

  task automatic test_back_pressure();
    apply_reset();
    sb.push_back({8'd0, 8'h11});
    sb.push_back({8'd1, 8'h22});
    sb.push_back({8'd2, 8'h33});
    sb.push_back({8'd3, 8'h44});
    bus.decode_ready = 1'b1;
    step();
    for (int c = 1; c <= 20 && sb.size() > 0; c++) begin
      bus.decode_ready = !(c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) begin
        total++; if (bus.instr_reg !== 8'h22) $display("FAIL stall_instr got %h exp 22", bus.instr_reg); else passed++;
        total++; if (bus.instr_pc !== 8'h01) $display("FAIL stall_instr_pc got %h exp 01", bus.instr_pc); else passed++;
        total++; if (bus.instruction_address !== 8'h02) $display("FAIL stall_pc got %h exp 02", bus.instruction_address); else passed++;
      end
      if (bus.instr_valid && bus.decode_ready) begin
        exp_item = sb.pop_front();
        total++; if (bus.instr_reg !== exp_item.word) $display("FAIL stall_seq_instr got %h exp %h", bus.instr_reg, exp_item.word); else passed++;
        total++; if (bus.instr_pc !== exp_item.pc) $display("FAIL stall_seq_pc got %h exp %h", bus.instr_pc, exp_item.pc); else passed++;
      end
      step();
    end
    bus.decode_ready = 1'b0;
    total++; if (sb.size() != 0) $display("FAIL stall_timeout left %0d exp 0", sb.size()); else passed++;
    total++; if (fetch_count !== 16'd4) $display("FAIL stall_count got %0d exp 4", fetch_count); else passed++;
  endtask

  task automatic test_wrap_halt();
    apply_reset();
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'd62;
    step();
    bus.branch_taken = 1'b0;
    sb.push_back({8'd62, 8'hAA});
    sb.push_back({8'd63, 8'h55});
    sb.push_back({8'd0, 8'hFF});
    bus.decode_ready = 1'b1;
    for (int c = 1; c <= 20 && sb.size() > 0; c++) begin
      if (bus.instr_valid && bus.decode_ready) begin
        exp_item = sb.pop_front();
        total++; if (bus.instr_reg !== exp_item.word) $display("FAIL wrap_instr got %h exp %h", bus.instr_reg, exp_item.word); else passed++;
        total++; if (bus.instr_pc !== exp_item.pc) $display("FAIL wrap_pc got %h exp %h", bus.instr_pc, exp_item.pc); else passed++;
        if (exp_item.word == 8'hFF) begin
          total++; if (fetch_state !== 2'b01) $display("FAIL halt_state got %b exp 01", fetch_state); else passed++;
          total++; if (bus.instruction_address !== 8'h00) $display("FAIL halt_pc got %h exp 00", bus.instruction_address); else passed++;
        end
      end
      step();
    end
    total++; if (sb.size() != 0) $display("FAIL wrap_timeout left %0d exp 0", sb.size()); else passed++;
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.instr_valid !== 1'b0) $display("FAIL halt_valid got %b exp 0", bus.instr_valid); else passed++;
      total++; if (fetch_state !== 2'b01) $display("FAIL halt_hold got %b exp 01", fetch_state); else passed++;
      total++; if (bus.instruction_address !== 8'h00) $display("FAIL halt_pc_hold got %h exp 00", bus.instruction_address); else passed++;
      step();
    end
    bus.decode_ready = 1'b0;
    total++; if (fetch_count !== 16'd3) $display("FAIL halt_count got %0d exp 3", fetch_count); else passed++;
  endtask

  task automatic test_branch();
    apply_reset();
    bus.decode_ready = 1'b1;
    step();
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h10;
    step();
    bus.branch_taken = 1'b0;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", bus.instr_valid); else passed++;
    total++; if (fetch_count !== 16'd0) $display("FAIL flush_count got %0d exp 0", fetch_count); else passed++;
    total++; if (bus.instruction_address !== 8'h10) $display("FAIL flush_pc got %h exp 10", bus.instruction_address); else passed++;
    step();
    total++; if (bus.instr_pc !== 8'h10) $display("FAIL target_instr_pc got %h exp 10", bus.instr_pc); else passed++;
    total++; if (bus.instr_reg !== 8'h3C) $display("FAIL target_instr got %h exp 3C", bus.instr_reg); else passed++;
    step();
    bus.decode_ready = 1'b0;
    total++; if (fetch_state !== 2'b01) $display("FAIL pre_branch_halt got %b exp 01", fetch_state); else passed++;
    total++; if (fetch_count !== 16'd1) $display("FAIL branch_count got %0d exp 1", fetch_count); else passed++;
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h20;
    step();
    bus.branch_taken = 1'b0;
    total++; if (fetch_state !== 2'b00) $display("FAIL halt_exit_state got %b exp 00", fetch_state); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL halt_exit_valid got %b exp 0", bus.instr_valid); else passed++;
    step();
    total++; if (bus.instr_reg !== 8'h77) $display("FAIL halt_exit_instr got %h exp 77", bus.instr_reg); else passed++;
    total++; if (bus.instr_pc !== 8'h20) $display("FAIL halt_exit_pc got %h exp 20", bus.instr_pc); else passed++;
  endtask

  task automatic test_fault();
    apply_reset();
    bus.decode_ready = 1'b1;
    step();
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h40;
    step();
    total++; if (fetch_state !== 2'b10) $display("FAIL fault_state got %b exp 10", fetch_state); else passed++;
    total++; if (fetch_fault !== 1'b1) $display("FAIL fault_flag got %b exp 1", fetch_fault); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL fault_valid got %b exp 0", bus.instr_valid); else passed++;
    total++; if (bus.instruction_address !== 8'h01) $display("FAIL fault_pc got %h exp 01", bus.instruction_address); else passed++;
    bus.branch_target = 8'h05;
    step();
    bus.branch_taken = 1'b0;
    total++; if (fetch_state !== 2'b10) $display("FAIL fault_sticky got %b exp 10", fetch_state); else passed++;
    total++; if (bus.instruction_address !== 8'h01) $display("FAIL fault_pc_hold got %h exp 01", bus.instruction_address); else passed++;
    step();
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL fault_no_load got %b exp 0", bus.instr_valid); else passed++;
    total++; if (fetch_count !== 16'd0) $display("FAIL fault_count got %0d exp 0", fetch_count); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.instruction_address !== 8'h00) $display("FAIL async_pc got %h exp 00", bus.instruction_address); else passed++;
    total++; if (bus.instr_reg !== 8'h00) $display("FAIL async_instr got %h exp 00", bus.instr_reg); else passed++;
    total++; if (bus.instr_pc !== 8'h00) $display("FAIL async_instr_pc got %h exp 00", bus.instr_pc); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL async_valid got %b exp 0", bus.instr_valid); else passed++;
    total++; if (fetch_state !== 2'b00) $display("FAIL async_state got %b exp 00", fetch_state); else passed++;
    total++; if (fetch_fault !== 1'b0) $display("FAIL async_fault got %b exp 0", fetch_fault); else passed++;
    total++; if (fetch_count !== 16'h0000) $display("FAIL async_count got %h exp 0000", fetch_count); else passed++;
    bus.decode_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h80);
    mem[0]    = 8'h11;
    mem[1]    = 8'h22;
    mem[2]    = 8'h33;
    mem[3]    = 8'h44;
    mem[8'h10] = 8'h3C;
    mem[8'h11] = 8'hFF;
    mem[8'h20] = 8'h77;
    mem[62]   = 8'hAA;
    mem[63]   = 8'h55;
    test_reset();
    test_straight_line();
    test_back_pressure();
    mem[0] = 8'hFF;
    test_wrap_halt();
    mem[0] = 8'h11;
    test_branch();
    test_fault();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
